// File: rtl/frac_baud_gen_if.sv
// frac_baud_gen_if: divisor configuration handshake for the fractional baud generator
interface frac_baud_gen_if #(
   parameter int DIV_W  = 16,
   parameter int FRAC_W = 4
);
   logic              cfg_valid;
   logic              cfg_ready;
   logic [DIV_W-1:0]  cfg_div;
   logic [FRAC_W-1:0] cfg_frac;
   logic              cfg_err;
   modport master (output cfg_valid, cfg_div, cfg_frac, input cfg_ready, cfg_err);
   modport slave  (input cfg_valid, cfg_div, cfg_frac, output cfg_ready, cfg_err);
endinterface

// File: rtl/frac_baud_gen.sv
// frac_baud_gen: fractional-N UART baud generator emitting oversample ticks, bit ticks and phase
module frac_baud_gen #(
   parameter int DIV_W        = 16,
   parameter int FRAC_W       = 4,
   parameter int OVERSAMPLING = 16,
   parameter int DEFAULT_DIV  = 27,
   parameter int DEFAULT_FRAC = 2,
   localparam int PH_W = OVERSAMPLING > 1 ? $clog2(OVERSAMPLING) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            enable,
   input  logic            sync,
   frac_baud_gen_if.slave  cfg,
   output logic            os_tick,
   output logic            bit_tick,
   output logic [PH_W-1:0] os_phase
);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLING - 1);
   localparam logic [DIV_W:0]  ONE     = (DIV_W + 1)'(1);
   logic [DIV_W-1:0]  div, cnt, sh_div;
   logic [FRAC_W-1:0] frac, acc, sh_frac;
   logic              carry, pending, term, apply, accept;
   logic [DIV_W:0]    cnt_inc, per;
   logic [FRAC_W:0]   sum;
   assign cnt_inc = {1'b0, cnt} + ONE;
   assign per     = {1'b0, div} + {{DIV_W{1'b0}}, carry};
   // >= rather than == so a smaller divisor applied while frozen still terminates
   assign term    = cnt_inc >= per;
   assign sum     = {1'b0, acc} + {1'b0, frac};
   assign accept  = cfg.cfg_valid && !pending;
   assign apply   = pending && (sync || !enable || term);
   assign cfg.cfg_ready = !pending;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         div         <= DIV_W'(DEFAULT_DIV);
         frac        <= FRAC_W'(DEFAULT_FRAC);
         sh_div      <= DIV_W'(DEFAULT_DIV);
         sh_frac     <= FRAC_W'(DEFAULT_FRAC);
         cnt         <= '0;
         acc         <= '0;
         carry       <= 1'b0;
         pending     <= 1'b0;
         os_phase    <= '0;
         os_tick     <= 1'b0;
         bit_tick    <= 1'b0;
         cfg.cfg_err <= 1'b0;
      end else begin
         os_tick     <= 1'b0;
         bit_tick    <= 1'b0;
         cfg.cfg_err <= accept && cfg.cfg_div < DIV_W'(2);
         if (accept && cfg.cfg_div >= DIV_W'(2)) begin
            sh_div  <= cfg.cfg_div;
            sh_frac <= cfg.cfg_frac;
            pending <= 1'b1;
         end
         if (sync) begin
            cnt      <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            os_phase <= '0;
         end else if (enable) begin
            cnt <= term ? '0 : cnt_inc[DIV_W-1:0];
            if (term) begin
               os_tick  <= 1'b1;
               bit_tick <= os_phase == PH_LAST;
               os_phase <= os_phase == PH_LAST ? '0 : os_phase + PH_W'(1);
               acc      <= sum[FRAC_W-1:0];
               carry    <= sum[FRAC_W];
            end
         end
         if (apply) begin
            div     <= sh_div;
            frac    <= sh_frac;
            acc     <= '0;
            carry   <= 1'b0;
            pending <= 1'b0;
         end
      end
endmodule

// File: tb/tb_frac_baud_gen.sv
// tb_frac_baud_gen: closed-form tick-time model checks for frac_baud_gen
module tb_frac_baud_gen;
   localparam int OVS = 16;
   localparam int FR  = 16;
   logic       clk = 1'b0, rst_n, enable, sync;
   logic       os_tick, bit_tick;
   logic [3:0] os_phase;
   longint     cyc = 0;
   int         n_assert = 0, n_fail = 0, err_cnt = 0, orphan = 0;
   longint     tick_q[$];
   int         ph_q[$];
   bit         bt_q[$];
   frac_baud_gen_if #(.DIV_W(16), .FRAC_W(4)) cfg_if ();
   frac_baud_gen dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .sync(sync), .cfg(cfg_if),
      .os_tick(os_tick), .bit_tick(bit_tick), .os_phase(os_phase)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk)
      if (rst_n) begin
         if (os_tick) begin
            tick_q.push_back(cyc);
            ph_q.push_back(int'(os_phase));
            bt_q.push_back(bit_tick);
         end
         if (bit_tick && !os_tick) orphan++;
         if (cfg_if.cfg_err) err_cnt++;
      end
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string tag, input longint obs, input longint exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic wait_until(input longint t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic do_sync(output longint t);
      sync = 1'b1;
      @(posedge clk);
      #1;
      sync = 1'b0;
      t = cyc;
      chk("sync_no_tick", os_tick, 0);
      chk("sync_phase", os_phase, 0);
   endtask
   task automatic offer(input int d, input int f);
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_div   = 16'(d);
      cfg_if.cfg_frac  = 4'(f);
      @(posedge clk);
      #1;
      cfg_if.cfg_valid = 1'b0;
   endtask
   // tick k after restart point t0 lands at t0 + k*d + floor((k-1)*f/2^FRAC_W)
   task automatic expect_seg(input longint t0, input int d, input int f, input int ph0,
                             input int base, input int k0, input int n);
      int budget;
      budget = n * (d + 1) + 100;
      while (tick_q.size() < base + n && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      #1;
      chk("tick_budget", tick_q.size() >= base + n, 1);
      if (tick_q.size() >= base + n)
         for (int k = k0; k <= n; k++) begin
            chk("tick_time", tick_q[base+k-1], t0 + longint'(k) * d + ((k - 1) * f) / FR);
            chk("os_phase", ph_q[base+k-1], (ph0 + k) % OVS);
            chk("bit_tick", bt_q[base+k-1], ((ph0 + k) % OVS) == 0);
         end
   endtask
   task automatic bit_period(input int base, input int n, input longint exp);
      longint b[$];
      for (int i = base; i < base + n && i < tick_q.size(); i++)
         if (bt_q[i]) b.push_back(tick_q[i]);
      chk("bit_found", b.size() >= 2, 1);
      if (b.size() >= 2) chk("bit_period", b[1] - b[0], exp);
   endtask
   initial begin
      longint t0, ts, tt;
      int base, nb, d, f, n_off;
      int d_l[6], f_l[6], eb[6];
      rst_n = 1'b0;
      enable = 1'b0;
      sync = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_div = '0;
      cfg_if.cfg_frac = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_os_tick", os_tick, 0);
      chk("rst_bit_tick", bit_tick, 0);
      chk("rst_cfg_err", cfg_if.cfg_err, 0);
      chk("rst_cfg_ready", cfg_if.cfg_ready, 1);
      chk("rst_os_phase", os_phase, 0);
      enable = 1'b1;
      rst_n = 1'b1;
      t0 = cyc;
      expect_seg(t0, 27, 2, 0, 0, 1, 32);
      bit_period(0, 32, 434);
      do_sync(t0);
      base = tick_q.size();
      wait_until(t0 + 40);
      offer(325, 0);
      chk("t2_ready_low", cfg_if.cfg_ready, 0);
      expect_seg(t0, 27, 2, 0, base, 1, 2);
      chk("t2_ready_back", cfg_if.cfg_ready, 1);
      expect_seg(t0 + 54, 325, 0, 2, base + 2, 1, 30);
      bit_period(base + 2, 30, 5200);
      d_l = '{10, 10, 10, 2, 0, 0};
      f_l = '{1, 8, 15, 15, 0, 0};
      eb  = '{161, 168, 175, 47, 0, 0};
      for (int i = 4; i < 6; i++) begin
         d_l[i] = int'($urandom_range(2, 40));
         f_l[i] = int'($urandom_range(0, 15));
         eb[i]  = OVS * d_l[i] + (OVS * f_l[i]) / FR;
      end
      for (int i = 0; i < 6; i++) begin
         offer(d_l[i], f_l[i]);
         do_sync(t0);
         base = tick_q.size();
         expect_seg(t0, d_l[i], f_l[i], 0, base, 1, 32);
         bit_period(base, 32, eb[i]);
      end
      d = 12;
      f = 5;
      offer(d, f);
      do_sync(t0);
      base = tick_q.size();
      err_cnt = 0;
      offer(1, 5);
      chk("err_div1", cfg_if.cfg_err, 1);
      chk("err_div1_ready", cfg_if.cfg_ready, 1);
      @(posedge clk);
      #1;
      chk("err_div1_width", cfg_if.cfg_err, 0);
      offer(0, 3);
      chk("err_div0", cfg_if.cfg_err, 1);
      chk("err_div0_ready", cfg_if.cfg_ready, 1);
      @(posedge clk);
      #1;
      chk("err_div0_width", cfg_if.cfg_err, 0);
      expect_seg(t0, d, f, 0, base, 1, 16);
      chk("err_count", err_cnt, 2);
      do_sync(t0);
      base = tick_q.size();
      expect_seg(t0, d, f, 0, base, 1, 7);
      chk("t5_phase7", os_phase, 7);
      do_sync(ts);
      base = tick_q.size();
      expect_seg(ts, d, f, 0, base, 1, 16);
      tt = ts + 17 * d + (16 * f) / FR;
      wait_until(tt - 1);
      do_sync(t0);
      base = tick_q.size();
      expect_seg(t0, d, f, 0, base, 1, 2);
      do_sync(t0);
      base = tick_q.size();
      expect_seg(t0, d, f, 0, base, 1, 1);
      wait_until(t0 + 15);
      n_off = int'($urandom_range(30, 60));
      nb = tick_q.size();
      enable = 1'b0;
      repeat (n_off) @(posedge clk);
      #1;
      chk("dis_no_ticks", tick_q.size(), nb);
      chk("dis_phase_hold", os_phase, 1);
      enable = 1'b1;
      expect_seg(t0 + n_off, d, f, 0, base, 2, 4);
      enable = 1'b0;
      offer(20, 0);
      chk("dis_cfg_pending", cfg_if.cfg_ready, 0);
      @(posedge clk);
      #1;
      chk("dis_cfg_applied", cfg_if.cfg_ready, 1);
      enable = 1'b1;
      do_sync(t0);
      base = tick_q.size();
      expect_seg(t0, 20, 0, 0, base, 1, 3);
      offer(100, 7);
      chk("rst_pending_set", cfg_if.cfg_ready, 0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ready", cfg_if.cfg_ready, 1);
      chk("arst_phase", os_phase, 0);
      chk("arst_os_tick", os_tick, 0);
      chk("arst_bit_tick", bit_tick, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      t0 = cyc;
      base = tick_q.size();
      expect_seg(t0, 27, 2, 0, base, 1, 16);
      chk("orphan_bit_tick", orphan, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
